uart_tx_peri: RTL

- Memory-mapped UART transmitter; the stage that produces the `tx` serial line of the RISC-V peripheral subsystem.
- The core writes bytes into a 4-entry FIFO over a simple single-cycle register bus.
- A frame engine serialises each byte as 8N1, LSB first, at a programmable bit period.
- Raises a level interrupt toward the core's interrupt input when the transmitter drains.

---
 rtl/uart_tx_peri.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_peri.sv
// Memory-mapped 8N1 UART transmitter: register bus, small byte FIFO, frame engine
// and a level interrupt that asserts once the transmitter has fully drained.
module uart_tx_peri #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy,
    output logic        tx_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             irq_en_q, irq_en_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d, busy_q, busy_d, irq_q, irq_d;

    logic empty, full, data_wr, push, pop, start, last_tick;
    logic [7:0] head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign data_wr   = wr_en && (addr == 2'd0);
    assign push      = data_wr && !full;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign last_tick = (cnt_q == period_q - DIV_W'(1));

    assign tx     = tx_q;
    assign busy   = busy_q;
    assign tx_irq = irq_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        div_d      = div_q;
        irq_en_d   = irq_en_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (data_wr && full) overflow_d = 1'b1;
        if (wr_en && addr == 2'd1 && wdata[3]) overflow_d = 1'b0;
        if (wr_en && addr == 2'd2) div_d = wdata[DIV_W-1:0];
        if (wr_en && addr == 2'd3) irq_en_d = wdata[0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + DIV_W'(1);
        period_d = period_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        pop      = 1'b0;
        start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (!empty) start = 1'b1;
            end
            S_START: begin
                if (last_tick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    if (!empty) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The bit period is captured here so a DIV write mid-frame only affects later frames.
        if (start) begin
            pop      = 1'b1;
            state_d  = S_START;
            shift_d  = head;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = '0;
            period_d = (div_q == '0) ? DIV_W'(1) : div_q;
        end
    end

    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign irq_d    = irq_en_q & empty & ~busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            irq_en_q   <= 1'b0;
            cnt_q      <= '0;
            period_q   <= DIV_W'(1);
            idx_q      <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            irq_en_q   <= irq_en_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                2'd1:    rdata[3:0] = {overflow_q, empty, full, busy_q};
                2'd2:    rdata[DIV_W-1:0] = div_q;
                2'd3:    rdata[0] = irq_en_q;
                default: rdata = '0;
            endcase
        end
    end
endmodule
